// File: rtl/sys_mem_arbiter.sv
// Four-port arbiter/sequencer in front of the single-ported shared system memory.
// Port 0 (processor) has priority; ports 1-3 rotate and override port 0 once starved.
module sys_mem_arbiter #(
  parameter int unsigned N             = 32,
  parameter int unsigned WORDS         = 128,
  parameter int unsigned ACCESS_CYCLES = 1,
  parameter int unsigned MAX_WAIT      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [3:0]   we,
  input  logic [N-1:0] addr0,
  input  logic [N-1:0] addr1,
  input  logic [N-1:0] addr2,
  input  logic [N-1:0] addr3,
  input  logic [N-1:0] wdata0,
  input  logic [N-1:0] wdata1,
  input  logic [N-1:0] wdata2,
  input  logic [N-1:0] wdata3,
  output logic [3:0]   ack,
  output logic         err,
  output logic [N-1:0] rdata,
  output logic         busy,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic         mem_read,
  output logic         mem_write,
  input  logic [N-1:0] mem_rdata
);

  localparam int unsigned CW = 4;
  localparam int unsigned WW = 8;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t         state;
  logic [1:0]     win;
  logic [1:0]     rr_ptr;
  logic [CW-1:0]  cnt;
  logic [WW-1:0]  wait_cnt [1:3];

  logic [3:0]     at_max_c;
  logic [1:0]     ord_c [3];
  logic           found_c;
  logic [1:0]     win_c;
  logic           we_sel_c;
  logic [N-1:0]   addr_sel_c;
  logic [N-1:0]   wdata_sel_c;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd3) ? 2'd1 : p + 2'd1;
  endfunction

  // Winner: starved port 1-3 in RR order, else port 0, else first requester in RR order.
  always_comb begin
    at_max_c = '0;
    for (int i = 1; i < 4; i++)
      at_max_c[i] = req[i] && (wait_cnt[i] == WW'(MAX_WAIT));
    ord_c[0] = nxt(rr_ptr);
    ord_c[1] = nxt(ord_c[0]);
    ord_c[2] = nxt(ord_c[1]);
    found_c  = 1'b0;
    win_c    = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (!found_c && at_max_c[ord_c[k]]) begin
        win_c   = ord_c[k];
        found_c = 1'b1;
      end
    end
    if (!found_c && req[0]) begin
      win_c   = 2'd0;
      found_c = 1'b1;
    end
    for (int k = 0; k < 3; k++) begin
      if (!found_c && req[ord_c[k]]) begin
        win_c   = ord_c[k];
        found_c = 1'b1;
      end
    end
  end

  always_comb begin
    addr_sel_c  = addr0;
    wdata_sel_c = wdata0;
    case (win_c)
      2'd1:    begin addr_sel_c = addr1; wdata_sel_c = wdata1; end
      2'd2:    begin addr_sel_c = addr2; wdata_sel_c = wdata2; end
      2'd3:    begin addr_sel_c = addr3; wdata_sel_c = wdata3; end
      default: begin addr_sel_c = addr0; wdata_sel_c = wdata0; end
    endcase
    we_sel_c = we[win_c];
  end

  // Sequencer plus wait counters; the strobe registers double as the latched direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      win       <= 2'd0;
      rr_ptr    <= 2'd3;
      cnt       <= '0;
      ack       <= '0;
      err       <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      for (int i = 1; i < 4; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < 4; i++) begin
        if (!req[i] || (state == DONE && win == 2'(i)))
          wait_cnt[i] <= '0;
        else if (!(state != IDLE && win == 2'(i)) && wait_cnt[i] < WW'(MAX_WAIT))
          wait_cnt[i] <= wait_cnt[i] + WW'(1);
      end

      case (state)
        IDLE: begin
          if (req != 4'b0000) begin
            win  <= win_c;
            busy <= 1'b1;
            cnt  <= CW'(ACCESS_CYCLES);
            if (addr_sel_c >= N'(WORDS)) begin
              // Out-of-range: report without touching memory.
              state <= DONE;
              ack   <= 4'b0001 << win_c;
              err   <= 1'b1;
              rdata <= '0;
            end else begin
              state     <= ACCESS;
              mem_addr  <= addr_sel_c;
              mem_wdata <= wdata_sel_c;
              mem_write <= we_sel_c;
              mem_read  <= !we_sel_c;
            end
          end
        end
        ACCESS: begin
          if (cnt == CW'(1)) begin
            rdata     <= mem_read ? mem_rdata : '0;
            err       <= 1'b0;
            ack       <= 4'b0001 << win;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          ack   <= '0;
          busy  <= 1'b0;
          if (win != 2'd0) rr_ptr <= win;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sys_mem_arbiter.sv
// Directed bench for sys_mem_arbiter: one-cycle-access instance for the main
// scenarios, a four-cycle-access instance for the mid-access reset scenario.
module tb_sys_mem_arbiter;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req, we;
  logic [N-1:0] addr0, addr1, addr2, addr3;
  logic [N-1:0] wdata0, wdata1, wdata2, wdata3;

  logic [3:0]   ack;
  logic         err, busy, mem_read, mem_write;
  logic [N-1:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic [3:0]   ack4;
  logic         err4, busy4, mem_read4, mem_write4;
  logic [N-1:0] rdata4, mem_addr4, mem_wdata4, mem_rdata4;

  logic [N-1:0] mem [128];
  logic         pre_we;
  logic [6:0]   pre_addr;
  logic [N-1:0] pre_data;

  int n_cmp = 0;
  int n_bad = 0;
  int ack_port[$];
  int ack_cyc[$];
  int c_hit;

  always #5 clk = ~clk;

  sys_mem_arbiter #(.N(N), .WORDS(128), .ACCESS_CYCLES(1), .MAX_WAIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  sys_mem_arbiter #(.N(N), .WORDS(128), .ACCESS_CYCLES(4), .MAX_WAIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .addr3(addr3),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
    .ack(ack4), .err(err4), .rdata(rdata4), .busy(busy4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4), .mem_read(mem_read4),
    .mem_write(mem_write4), .mem_rdata(mem_rdata4)
  );

  // Memory model: combinational read, write on the edge closing the strobe cycle.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (mem_write && mem_addr < 32'd128) mem[mem_addr[6:0]] <= mem_wdata;
  end
  assign mem_rdata  = (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : '0;
  assign mem_rdata4 = 32'h5A5A_0000 ^ {25'd0, mem_addr4[6:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int idx(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return i;
    return -1;
  endfunction

  initial begin
    rst_n = 1'b0; req = '0; we = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    addr0 = '0; addr1 = '0; addr2 = '0; addr3 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0; wdata3 = '0;
    tick(); tick();

    // Reset values
    chk("rst_ack",   32'(ack), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    chk("rst_mrd",   32'(mem_read), 32'h0);
    chk("rst_mwr",   32'(mem_write), 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mwd",   mem_wdata, 32'h0);

    pre_we = 1'b1; pre_addr = 7'd5; pre_data = 32'hDEAD_BEEF; tick();
    pre_addr = 7'd0; pre_data = 32'hCAFE_0000; tick();
    pre_we = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single read of word 5 from port 0
    req = 4'b0001; we = 4'b0000; addr0 = 32'd5; wdata0 = 32'h1111_1111;
    tick();
    chk("rd_strobe", 32'(mem_read), 32'h1);
    chk("rd_nowr",   32'(mem_write), 32'h0);
    chk("rd_addr",   mem_addr, 32'd5);
    chk("rd_busy",   32'(busy), 32'h1);
    chk("rd_noack",  32'(ack), 32'h0);
    tick();
    chk("rd_ack",    32'(ack), 32'h1);
    chk("rd_data",   rdata, 32'hDEAD_BEEF);
    chk("rd_err",    32'(err), 32'h0);
    chk("rd_mrd_off", 32'(mem_read), 32'h0);
    chk("rd_nowr2",  32'(mem_write), 32'h0);
    req = 4'b0000;
    tick();
    chk("rd_ackclr", 32'(ack), 32'h0);
    chk("rd_idle",   32'(busy), 32'h0);
    chk("rd_hold",   rdata, 32'hDEAD_BEEF);

    // Fixed priority: three writers at once
    req = 4'b0111; we = 4'b0111;
    addr0 = 32'd10; wdata0 = 32'hA000_0000;
    addr1 = 32'd11; wdata1 = 32'hA111_1111;
    addr2 = 32'd12; wdata2 = 32'hA222_2222;
    ack_port.delete(); ack_cyc.delete();
    for (int c = 1; c <= 20 && req != 4'b0000; c++) begin
      tick();
      chk("pri_excl", 32'(mem_read & mem_write), 32'h0);
      if (ack != 4'b0000) begin
        ack_port.push_back(idx(ack));
        ack_cyc.push_back(c);
        req = req & ~ack;
      end
    end
    tick();
    chk("pri_count", 32'(ack_port.size()), 32'd3);
    for (int k = 0; k < ack_port.size() && k < 3; k++) begin
      chk("pri_port", 32'(ack_port[k]), 32'(k));
      chk("pri_cyc",  32'(ack_cyc[k]), 32'(2 + 3 * k));
    end
    chk("pri_mem10", mem[10], 32'hA000_0000);
    chk("pri_mem11", mem[11], 32'hA111_1111);
    chk("pri_mem12", mem[12], 32'hA222_2222);

    // Round robin among ports 1-3
    do_reset();
    req = 4'b1110; we = 4'b0000;
    addr1 = 32'd20; addr2 = 32'd21; addr3 = 32'd22;
    ack_port.delete(); ack_cyc.delete();
    for (int c = 1; c <= 40 && ack_port.size() < 6; c++) begin
      tick();
      chk("rr_excl", 32'(mem_read & mem_write), 32'h0);
      if (ack != 4'b0000) ack_port.push_back(idx(ack));
    end
    req = 4'b0000;
    tick(); tick();
    chk("rr_count", 32'(ack_port.size()), 32'd6);
    for (int k = 0; k < ack_port.size() && k < 6; k++)
      chk("rr_port", 32'(ack_port[k]), 32'((k % 3) + 1));

    // Starvation override of port 0 by port 2
    do_reset();
    req = 4'b0101; we = 4'b0000; addr0 = 32'd1; addr2 = 32'd2;
    ack_port.delete(); ack_cyc.delete();
    for (int c = 1; c <= 30 && req != 4'b0000; c++) begin
      tick();
      if (ack != 4'b0000) begin
        ack_port.push_back(idx(ack));
        ack_cyc.push_back(c);
        if (ack[2]) req = 4'b0000;
      end
    end
    tick();
    chk("stv_count", 32'(ack_port.size()), 32'd3);
    if (ack_port.size() == 3) begin
      chk("stv_p0a", 32'(ack_port[0]), 32'd0);
      chk("stv_p0b", 32'(ack_port[1]), 32'd0);
      chk("stv_p2",  32'(ack_port[2]), 32'd2);
      chk("stv_cyc", 32'(ack_cyc[2]), 32'd8);
    end

    // Out-of-range write from port 3
    tick();
    req = 4'b1000; we = 4'b1000; addr3 = 32'd128; wdata3 = 32'h1234_5678;
    tick();
    chk("rng_ack",   32'(ack), 32'h8);
    chk("rng_err",   32'(err), 32'h1);
    chk("rng_rdata", rdata, 32'h0);
    chk("rng_nowr",  32'(mem_write), 32'h0);
    chk("rng_nord",  32'(mem_read), 32'h0);
    chk("rng_busy",  32'(busy), 32'h1);
    req = 4'b0000;
    tick();
    chk("rng_ackclr", 32'(ack), 32'h0);
    chk("rng_idle",   32'(busy), 32'h0);
    chk("rng_nowr2",  32'(mem_write), 32'h0);
    chk("rng_mem0",   mem[0], 32'hCAFE_0000);

    // Mid-access reset on the four-cycle instance, after moving its pointer to 2
    do_reset();
    req = 4'b0100; we = 4'b0000; addr2 = 32'd3;
    c_hit = -1;
    for (int c = 1; c <= 12 && c_hit < 0; c++) begin
      tick();
      if (ack4[2]) c_hit = c;
    end
    chk("rst4_p2_lat", 32'(c_hit), 32'd5);
    req = 4'b0000;
    tick();
    req = 4'b0001; addr0 = 32'd7; wdata0 = 32'h0000_0077;
    tick();
    chk("rst4_s1", 32'(mem_read4), 32'h1);
    tick();
    chk("rst4_s2",    32'(mem_read4), 32'h1);
    chk("rst4_addr",  mem_addr4, 32'd7);
    chk("rst4_wdata", mem_wdata4, 32'h0000_0077);
    #2 rst_n = 1'b0;
    #1;
    chk("rst4_mrd",  32'(mem_read4), 32'h0);
    chk("rst4_mwr",  32'(mem_write4), 32'h0);
    chk("rst4_busy", 32'(busy4), 32'h0);
    chk("rst4_ack",  32'(ack4), 32'h0);
    req = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst4_noack", 32'(ack4), 32'h0);
      chk("rst4_idle",  32'(busy4), 32'h0);
    end
    req = 4'b1110; we = 4'b0000; addr1 = 32'd9; addr2 = 32'd10; addr3 = 32'd11;
    c_hit = -1;
    for (int c = 1; c <= 12 && c_hit < 0; c++) begin
      tick();
      if (ack4 != 4'b0000) begin
        c_hit = c;
        chk("rst4_rr",    32'(idx(ack4)), 32'd1);
        chk("rst4_rdata", rdata4, 32'h5A5A_0009);
        chk("rst4_err",   32'(err4), 32'h0);
      end
    end
    chk("rst4_rr_lat", 32'(c_hit), 32'd5);
    req = 4'b0000;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
